// File: rtl/shifter_pkg.sv
// Shared encodings and the stage-1 decoded record for the pipelined operand shifter.
package shifter_pkg;

  localparam logic [2:0] MODE_IMM_ROT   = 3'b000;
  localparam logic [2:0] MODE_SHIFT_IMM = 3'b001;
  localparam logic [2:0] MODE_SHIFT_REG = 3'b010;
  localparam logic [2:0] MODE_LS_IMM    = 3'b100;
  localparam logic [2:0] MODE_LS_REG    = 3'b101;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Every mode is reduced to one barrel-shifter request plus an illegal flag.
  typedef struct packed {
    logic [1:0] sh_type;
    logic [7:0] amt;
    logic       rrx;
    logic       c_in;
    logic       illegal;
  } stage1_t;

endpackage

// File: rtl/shift_core.sv
// Combinational ARM barrel shifter with register-shift semantics for amounts 0..255.
// Amount 0 passes rm and c_in through; rrx overrides type and amount.
module shift_core
  import shifter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        sh_type,
  input  logic [7:0]        amt,
  input  logic              rrx,
  input  logic [DATA_W-1:0] rm,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  localparam int AW = $clog2(DATA_W);

  logic [AW-1:0]   s;
  logic [AW:0]     inv_s;
  logic            oob;
  logic            eq;
  logic [DATA_W:0] lsl_w;
  logic [DATA_W:0] lsr_w;
  logic [DATA_W:0] asr_w;
  logic [DATA_W-1:0] ror_w;

  assign s     = amt[AW-1:0];
  assign inv_s = (AW+1)'(DATA_W) - {1'b0, s};
  assign oob   = {1'b0, amt} >= 9'(DATA_W);
  assign eq    = {1'b0, amt} == 9'(DATA_W);
  // Extra bit on the shifted-out side captures the last bit lost.
  assign lsl_w = {1'b0, rm} << s;
  assign lsr_w = {rm, 1'b0} >> s;
  assign asr_w = $signed({rm, 1'b0}) >>> s;
  assign ror_w = (rm >> s) | (rm << inv_s);

  always_comb begin
    result = rm;
    carry  = c_in;
    if (rrx) begin
      result = {c_in, rm[DATA_W-1:1]};
      carry  = rm[0];
    end else if (amt != 8'd0) begin
      case (sh_type)
        SH_LSL: begin
          if (!oob) begin
            {carry, result} = lsl_w;
          end else begin
            result = '0;
            carry  = eq ? rm[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (!oob) begin
            result = lsr_w[DATA_W:1];
            carry  = lsr_w[0];
          end else begin
            result = '0;
            carry  = eq ? rm[DATA_W-1] : 1'b0;
          end
        end
        SH_ASR: begin
          if (!oob) begin
            result = asr_w[DATA_W:1];
            carry  = asr_w[0];
          end else begin
            result = {DATA_W{rm[DATA_W-1]}};
            carry  = rm[DATA_W-1];
          end
        end
        default: begin
          result = ror_w;
          carry  = ror_w[DATA_W-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/pipelined_operand_shifter.sv
// ARM addressing-mode 1/2 operand shifter, PIPE_STAGES cycles latency, stalls on !out_ready.
// SHIFTER_REGSHIFT_EN enables shift-by-register (mode 010); without it that mode is illegal.
module pipelined_operand_shifter
  import shifter_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        mode,
  input  logic [11:0]       l_field,
  input  logic [DATA_W-1:0] rm,
  input  logic [DATA_W-1:0] rs,
  input  logic              c_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              carry_out,
  output logic [TAG_W-1:0]  tag_out,
  output logic              illegal
);

  stage1_t           rec_d;
  logic [DATA_W-1:0] opnd_d;
  stage1_t           core_rec;
  logic [DATA_W-1:0] core_opnd;
  logic [TAG_W-1:0]  core_tag;
  logic              core_vld;
  logic [DATA_W-1:0] core_res;
  logic              core_carry;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              carry_q;
  logic [TAG_W-1:0]  tag_q;
  logic              illegal_q;
  logic              adv;

`ifdef SHIFTER_REGSHIFT_EN
  logic unused_rs;
  assign unused_rs = ^rs[DATA_W-1:8];
`else
  logic unused_rs;
  assign unused_rs = ^rs;
`endif

  always_comb begin
    rec_d         = '0;
    rec_d.sh_type = SH_LSL;
    rec_d.c_in    = c_in;
    opnd_d        = rm;
    case (mode)
      MODE_IMM_ROT: begin
        opnd_d        = {{(DATA_W-8){1'b0}}, l_field[7:0]};
        rec_d.sh_type = SH_ROR;
        rec_d.amt     = {3'b000, l_field[11:8], 1'b0};
      end
      MODE_SHIFT_IMM: begin
        rec_d.sh_type = l_field[6:5];
        rec_d.amt     = {3'b000, l_field[11:7]};
        // An immediate amount of zero encodes the special cases LSR/ASR #32 and RRX.
        if (l_field[11:7] == 5'd0) begin
          case (l_field[6:5])
            SH_LSR, SH_ASR: rec_d.amt = 8'(DATA_W);
            SH_ROR:         rec_d.rrx = 1'b1;
            default:        rec_d.amt = 8'd0;
          endcase
        end
      end
      MODE_SHIFT_REG: begin
`ifdef SHIFTER_REGSHIFT_EN
        rec_d.sh_type = l_field[6:5];
        rec_d.amt     = rs[7:0];
`else
        rec_d.illegal = 1'b1;
`endif
      end
      MODE_LS_IMM: opnd_d = {{(DATA_W-12){1'b0}}, l_field};
      MODE_LS_REG: opnd_d = rm;
      default:     rec_d.illegal = 1'b1;
    endcase
  end

  // The whole pipe moves together whenever the output slot is free or draining.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  generate
    if (PIPE_STAGES == 2) begin : g_two
      logic              s1_vld_q;
      stage1_t           s1_q;
      logic [DATA_W-1:0] s1_opnd_q;
      logic [TAG_W-1:0]  s1_tag_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_vld_q  <= 1'b0;
          s1_q      <= '0;
          s1_opnd_q <= '0;
          s1_tag_q  <= '0;
        end else if (adv) begin
          s1_vld_q <= in_valid;
          if (in_valid) begin
            s1_q      <= rec_d;
            s1_opnd_q <= opnd_d;
            s1_tag_q  <= tag_in;
          end
        end
      end

      assign core_vld  = s1_vld_q;
      assign core_rec  = s1_q;
      assign core_opnd = s1_opnd_q;
      assign core_tag  = s1_tag_q;
    end else begin : g_one
      assign core_vld  = in_valid;
      assign core_rec  = rec_d;
      assign core_opnd = opnd_d;
      assign core_tag  = tag_in;
    end
  endgenerate

  shift_core #(.DATA_W(DATA_W)) u_core (
    .sh_type (core_rec.sh_type),
    .amt     (core_rec.amt),
    .rrx     (core_rec.rrx),
    .rm      (core_opnd),
    .c_in    (core_rec.c_in),
    .result  (core_res),
    .carry   (core_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      carry_q     <= 1'b0;
      tag_q       <= '0;
      illegal_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= core_vld;
      if (core_vld) begin
        out_data_q <= core_res;
        carry_q    <= core_carry;
        tag_q      <= core_tag;
        illegal_q  <= core_rec.illegal;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign carry_out = carry_q;
  assign tag_out   = tag_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/pipelined_operand_shifter.md
Name: pipelined_operand_shifter

Overview:
- Registered, handshaked successor to the combinational operand shifter in the pipeline's execute stage.
- Produces the ARM shifter_operand and shifter_carry_out for Addressing Mode 1, and the offset for Addressing Mode 2.
- Parametrised in data width and pipeline depth.
- Adds shift-by-register modes (ARM A5.1.6/8/10/12) and a valid/ready interface so execute can stall it.

Parameters:
DATA_W, 32, datapath width; power of two, >= 16
PIPE_STAGES, 2, latency in cycles; legal values 1 or 2
TAG_W, 5, width of a sideband tag (destination register id) carried alongside the result

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
mode  in  3  000 imm-rotate, 001 shift-by-imm, 010 shift-by-reg, 100 LS imm offset, 101 LS reg offset
l_field  in  12  instruction bits [11:0]
rm  in  DATA_W  Rm operand
rs  in  DATA_W  Rs operand; only bits [7:0] used
c_in  in  1  current CPSR C flag
tag_in  in  TAG_W  sideband tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_data  out  DATA_W  shifter operand / offset
carry_out  out  1  shifter_carry_out
tag_out  out  TAG_W  tag of the result
illegal  out  1  mode was 011, 110 or 111 (or 010 with the option off)

Behaviour:
- Reset (async, rst_n=0): all stage valid bits = 0; out_valid=0; out_data=0; carry_out=0; tag_out=0; illegal=0. Reset mid-operation discards in-flight results.
- Handshake:
  - Transfer on in_valid&in_ready.
  - in_ready = !stage_valid[last] | out_ready. This is combinational, with no dependency on in_valid.
  - Each stage advances when the stage downstream of it is empty or advancing.
  - Outputs hold stable while out_valid&!out_ready.
  - Latency is exactly PIPE_STAGES cycles with no stall. Throughput is 1 per cycle.
- PIPE_STAGES=2: stage 1 registers decoded shift type, effective amount, rm and c_in. Stage 2 registers the shifted result. PIPE_STAGES=1: one register after full compute.
- Imm-rotate (000): imm8 = l_field[7:0], zero-extended; rotate right by 2*l_field[11:8]. Carry = c_in if rot=0, else result[DATA_W-1].
- Shift-by-imm (001): amount = l_field[11:7], type = l_field[6:5].
  - LSL#0: rm, carry c_in.
  - LSR#0 means shift by 32: result 0, carry rm[31].
  - ASR#0: all bits = rm[DATA_W-1], carry = rm[DATA_W-1].
  - ROR#0 = RRX: {c_in, rm[DATA_W-1:1]}, carry rm[0].
  - Otherwise the normal shift; carry is the last bit shifted out.
- Shift-by-reg (010): amount a = rs[7:0]; type = l_field[6:5].
  - a=0, any type: rm, carry c_in.
  - LSL: a<DATA_W gives rm<<a, carry rm[DATA_W-a]. a=DATA_W gives 0, carry rm[0]. a>DATA_W gives 0, carry 0.
  - LSR: a<DATA_W gives rm>>a, carry rm[a-1]. a=DATA_W gives 0, carry rm[DATA_W-1]. a>DATA_W gives 0, carry 0.
  - ASR: a>=DATA_W gives sign fill, carry = sign bit.
  - ROR: let r = a mod DATA_W. r=0 gives rm, carry rm[DATA_W-1]. Otherwise rotate by r, carry rm[r-1].
- LS imm (100): out_data = zero-extended l_field, carry c_in. LS reg (101): out_data = rm, carry c_in.
- Illegal modes: out_data = rm, carry = c_in, illegal=1, travelling with the result. The block never hangs.
- All arithmetic is unsigned except ASR. No X propagation: unused rs bits are ignored.

Optional Feature:
SHIFTER_REGSHIFT_EN
- Defined: mode 010 behaves as above.
- Undefined: the shift-by-register logic is not synthesised; mode 010 is treated as illegal (out_data=rm, carry=c_in, illegal=1). This saves area for cores that trap register-specified shifts.

Decomposition:
- Shared package shifter_pkg:
  - mode encodings (MODE_IMM_ROT, MODE_SHIFT_IMM, MODE_SHIFT_REG, MODE_LS_IMM, MODE_LS_REG);
  - shift-type constants (SH_LSL, SH_LSR, SH_ASR, SH_ROR);
  - a struct for the stage-1 decoded record.
- One sub-module, shift_core: a purely combinational barrel shifter. It takes (type, 8-bit amount, rrx flag, rm, c_in) and returns (result, carry). All modes map onto it.

Test Plan:
1. Imm-rotate, l_field=0x4FF, c_in=0 -> out_data=0xFF000000, carry=1, after exactly PIPE_STAGES cycles.
2. Shift-by-reg LSL, rm=0x80000001, rs=32 -> 0x00000000, carry=1; rs=33 -> 0, carry 0; rs=0 with c_in=1 -> 0x80000001, carry 1.
3. Shift-by-imm ROR#0 (RRX), rm=0x00000003, c_in=1 -> 0x80000001, carry=1. Shift-by-imm ASR#0, rm=0x80000000 -> 0xFFFFFFFF, carry 1.
4. Back-to-back 8 requests with out_ready toggled 1,0,0,1: no loss, no duplication, in-order tags, outputs stable while stalled, in_ready=0 only when full and out_ready=0.
5. rst_n asserted low with 2 requests in flight -> out_valid=0 immediately (async); after release the first new request returns after PIPE_STAGES cycles.
6. mode=111, rm=0x1234 -> out_data=0x1234, illegal=1. mode=010 with SHIFTER_REGSHIFT_EN undefined -> illegal=1.
